// File: rtl/snake_pkg.sv
// Shared definitions for the snake segment mover.
// Provides the direction encodings, a reversal test helper and a coordinate pair type.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;  // y - 1
  localparam logic [1:0] DIR_DOWN  = 2'b01;  // y + 1
  localparam logic [1:0] DIR_LEFT  = 2'b10;  // x - 1
  localparam logic [1:0] DIR_RIGHT = 2'b11;  // x + 1

  // Widest coordinate the pair type can carry; narrower grids zero-extend.
  localparam int unsigned CoordWMax = 8;

  typedef struct packed {
    logic [CoordWMax-1:0] x;
    logic [CoordWMax-1:0] y;
  } coord_t;

  // Opposite directions share the axis bit [1] and differ in the sign bit [0].
  function automatic logic is_opposite(logic [1:0] a, logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator.
// Ports:
//   head_x, head_y  current head coordinate
//   dir             effective direction for this move
//   next_x, next_y  head after one step (modulo 2^COORD_W)
//   wall            step would leave the grid (always 0 when WRAP = 1)
module snake_next_head
  import snake_pkg::*;
#(
  parameter int unsigned COORD_W = 3,
  parameter bit          WRAP    = 1'b0
) (
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic [1:0]         dir,
  output logic [COORD_W-1:0] next_x,
  output logic [COORD_W-1:0] next_y,
  output logic               wall
);

  localparam logic [COORD_W-1:0] One  = COORD_W'(1);
  localparam logic [COORD_W-1:0] Last = '1;

  logic edge_hit;

  // Truncating arithmetic gives the wrap-around for free; the edge flag
  // records whether that wrap happened.
  always_comb begin
    next_x   = head_x;
    next_y   = head_y;
    edge_hit = 1'b0;
    unique case (dir)
      DIR_UP: begin
        next_y   = head_y - One;
        edge_hit = (head_y == '0);
      end
      DIR_DOWN: begin
        next_y   = head_y + One;
        edge_hit = (head_y == Last);
      end
      DIR_LEFT: begin
        next_x   = head_x - One;
        edge_hit = (head_x == '0);
      end
      DIR_RIGHT: begin
        next_x   = head_x + One;
        edge_hit = (head_x == Last);
      end
    endcase
  end

  assign wall = WRAP ? 1'b0 : edge_hit;

endmodule

// File: rtl/snake_segments.sv
// Variable-length snake mover with wall/wrap boundaries, self-collision detection,
// sticky game-over and a combinational occupancy query.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   move_enable           advance one cell this cycle (ignored once dead)
//   direction             requested direction; reversal onto heading is ignored
//   grow                  keep the tail on this move (sampled with move_enable)
//   query_x, query_y      cell to test; query_hit is combinational
//   head_x, head_y        segment 0
//   seg_x, seg_y          flattened segments, inactive entries read 0
//   length, heading       active segment count and effective direction
//   alive, wall_hit, self_hit  game state and sticky collision cause
module snake_segments
  import snake_pkg::*;
#(
  parameter int unsigned COORD_W  = 3,
  parameter int unsigned MAX_LEN  = 8,
  parameter int unsigned INIT_LEN = 3,
  parameter bit          WRAP     = 1'b0,
  parameter int unsigned LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       move_enable,
  input  logic [1:0]                 direction,
  input  logic                       grow,
  input  logic [COORD_W-1:0]         query_x,
  input  logic [COORD_W-1:0]         query_y,
  output logic                       query_hit,
  output logic [COORD_W-1:0]         head_x,
  output logic [COORD_W-1:0]         head_y,
  output logic [MAX_LEN*COORD_W-1:0] seg_x,
  output logic [MAX_LEN*COORD_W-1:0] seg_y,
  output logic [LEN_W-1:0]           length,
  output logic [1:0]                 heading,
  output logic                       alive,
  output logic                       wall_hit,
  output logic                       self_hit
);

  localparam logic [COORD_W-1:0] Mid    = COORD_W'(1 << (COORD_W - 1));
  localparam logic [LEN_W-1:0]   MaxLen = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   InitLn = LEN_W'(INIT_LEN);

  logic [COORD_W-1:0] seg_x_q [MAX_LEN];
  logic [COORD_W-1:0] seg_y_q [MAX_LEN];
  logic [COORD_W-1:0] seg_x_d [MAX_LEN];
  logic [COORD_W-1:0] seg_y_d [MAX_LEN];
  logic [LEN_W-1:0]   length_q, length_d;
  logic [1:0]         heading_q, heading_d;
  logic               alive_q, alive_d;
  logic               wall_hit_q, wall_hit_d;
  logic               self_hit_q, self_hit_d;

  logic [1:0]         eff_dir;
  logic [COORD_W-1:0] next_x, next_y;
  logic               wall;
  logic               grow_eff;
  logic [LEN_W-1:0]   keep_len;
  logic [MAX_LEN-1:0] self_vec;
  logic [MAX_LEN-1:0] query_vec;
  logic               self_col;
  logic               do_move;

  assign eff_dir = is_opposite(direction, heading_q) ? heading_q : direction;

  snake_next_head #(
    .COORD_W (COORD_W),
    .WRAP    (WRAP)
  ) u_next_head (
    .head_x (seg_x_q[0]),
    .head_y (seg_y_q[0]),
    .dir    (eff_dir),
    .next_x (next_x),
    .next_y (next_y),
    .wall   (wall)
  );

  // Growing at full length degenerates to a plain move, so the tail vacates.
  assign grow_eff = grow && (length_q < MaxLen);
  // Segments still occupied after the move: indices below keep_len.
  assign keep_len = grow_eff ? length_q : length_q - LEN_W'(1);
  assign do_move  = move_enable && alive_q;

  always_comb begin
    self_vec  = '0;
    query_vec = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      self_vec[i]  = (seg_x_q[i] == next_x) && (seg_y_q[i] == next_y) &&
                     (LEN_W'(i) < keep_len);
      query_vec[i] = (seg_x_q[i] == query_x) && (seg_y_q[i] == query_y) &&
                     (LEN_W'(i) < length_q);
    end
  end

  assign self_col  = |self_vec;
  assign query_hit = |query_vec;

  // Next-state: a collision freezes the body and only records the cause.
  always_comb begin
    seg_x_d    = seg_x_q;
    seg_y_d    = seg_y_q;
    length_d   = length_q;
    heading_d  = heading_q;
    alive_d    = alive_q;
    wall_hit_d = wall_hit_q;
    self_hit_d = self_hit_q;
    if (do_move) begin
      if (wall) begin
        alive_d    = 1'b0;
        wall_hit_d = 1'b1;
      end else if (self_col) begin
        alive_d    = 1'b0;
        self_hit_d = 1'b1;
      end else begin
        heading_d  = eff_dir;
        length_d   = grow_eff ? length_q + LEN_W'(1) : length_q;
        seg_x_d[0] = next_x;
        seg_y_d[0] = next_y;
        // Entries past the new length are cleared so inactive slots read 0.
        for (int i = 1; i < int'(MAX_LEN); i++) begin
          if (LEN_W'(i) < length_d) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end else begin
            seg_x_d[i] = '0;
            seg_y_d[i] = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        if (i < int'(INIT_LEN)) begin
          seg_x_q[i] <= Mid;
          seg_y_q[i] <= Mid - COORD_W'(i);
        end else begin
          seg_x_q[i] <= '0;
          seg_y_q[i] <= '0;
        end
      end
      length_q   <= InitLn;
      heading_q  <= DIR_DOWN;
      alive_q    <= 1'b1;
      wall_hit_q <= 1'b0;
      self_hit_q <= 1'b0;
    end else begin
      seg_x_q    <= seg_x_d;
      seg_y_q    <= seg_y_d;
      length_q   <= length_d;
      heading_q  <= heading_d;
      alive_q    <= alive_d;
      wall_hit_q <= wall_hit_d;
      self_hit_q <= self_hit_d;
    end
  end

  always_comb begin
    seg_x = '0;
    seg_y = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      seg_x[i*COORD_W +: COORD_W] = seg_x_q[i];
      seg_y[i*COORD_W +: COORD_W] = seg_y_q[i];
    end
  end

  assign head_x   = seg_x_q[0];
  assign head_y   = seg_y_q[0];
  assign length   = length_q;
  assign heading  = heading_q;
  assign alive    = alive_q;
  assign wall_hit = wall_hit_q;
  assign self_hit = self_hit_q;

endmodule

// File: tb/tb_snake_segments.sv
module tb_snake_segments;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        move_enable = 1'b0;
  logic [1:0]  direction = 2'b01;
  logic        grow = 1'b0;
  logic [2:0]  query_x = '0;
  logic [2:0]  query_y = '0;

  // Wall-mode instance
  logic        w_query_hit, w_alive, w_wall_hit, w_self_hit;
  logic [2:0]  w_head_x, w_head_y;
  logic [23:0] w_seg_x, w_seg_y;
  logic [3:0]  w_length;
  logic [1:0]  w_heading;
  // Wrap-mode instance
  logic        r_query_hit, r_alive, r_wall_hit, r_self_hit;
  logic [2:0]  r_head_x, r_head_y;
  logic [23:0] r_seg_x, r_seg_y;
  logic [3:0]  r_length;
  logic [1:0]  r_heading;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  snake_segments #(.COORD_W(3), .MAX_LEN(8), .INIT_LEN(3), .WRAP(1'b0)) dut_wall (
    .clk(clk), .reset(reset), .move_enable(move_enable), .direction(direction), .grow(grow),
    .query_x(query_x), .query_y(query_y), .query_hit(w_query_hit),
    .head_x(w_head_x), .head_y(w_head_y), .seg_x(w_seg_x), .seg_y(w_seg_y),
    .length(w_length), .heading(w_heading), .alive(w_alive),
    .wall_hit(w_wall_hit), .self_hit(w_self_hit)
  );

  snake_segments #(.COORD_W(3), .MAX_LEN(8), .INIT_LEN(3), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .reset(reset), .move_enable(move_enable), .direction(direction), .grow(grow),
    .query_x(query_x), .query_y(query_y), .query_hit(r_query_hit),
    .head_x(r_head_x), .head_y(r_head_y), .seg_x(r_seg_x), .seg_y(r_seg_y),
    .length(r_length), .heading(r_heading), .alive(r_alive),
    .wall_hit(r_wall_hit), .self_hit(r_self_hit)
  );

  task automatic do_reset(input logic me);
    reset = 1'b1;
    move_enable = me;
    direction = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    move_enable = 1'b0;
  endtask

  task automatic do_move(input logic [1:0] d, input logic g);
    direction = d;
    grow = g;
    move_enable = 1'b1;
    @(posedge clk);
    #1;
    move_enable = 1'b0;
    grow = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    vectors++; if ({w_head_x, w_head_y} !== 6'o44) begin miscompares++;
      $display("FAIL reset_head got %o want 44", {w_head_x, w_head_y}); end
    vectors++; if (w_seg_x !== 24'o00000444) begin miscompares++;
      $display("FAIL reset_seg_x got %o want 00000444", w_seg_x); end
    vectors++; if (w_seg_y !== 24'o00000234) begin miscompares++;
      $display("FAIL reset_seg_y got %o want 00000234", w_seg_y); end
    vectors++; if (w_length !== 4'd3) begin miscompares++;
      $display("FAIL reset_length got %0d want 3", w_length); end
    vectors++; if ({w_heading, w_alive, w_wall_hit, w_self_hit} !== 5'b01100) begin
      miscompares++;
      $display("FAIL reset_state got %b want 01100",
               {w_heading, w_alive, w_wall_hit, w_self_hit}); end
    query_x = 3'd4; query_y = 3'd2; #1;
    vectors++; if (w_query_hit !== 1'b1) begin miscompares++;
      $display("FAIL query_tail got %b want 1", w_query_hit); end
    query_y = 3'd1; #1;
    vectors++; if (w_query_hit !== 1'b0) begin miscompares++;
      $display("FAIL query_empty got %b want 0", w_query_hit); end
    // During a move cycle the query still sees the pre-move body.
    query_y = 3'd5; direction = 2'b01; move_enable = 1'b1; #1;
    vectors++; if (w_query_hit !== 1'b0) begin miscompares++;
      $display("FAIL query_premove got %b want 0", w_query_hit); end
    @(posedge clk); #1; move_enable = 1'b0;
    vectors++; if (w_query_hit !== 1'b1) begin miscompares++;
      $display("FAIL query_postmove got %b want 1", w_query_hit); end
  endtask

  task automatic test_wall_wrap;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) do_move(2'b01, 1'b0);
    vectors++; if ({w_head_x, w_head_y} !== 6'o47) begin miscompares++;
      $display("FAIL edge_head got %o want 47", {w_head_x, w_head_y}); end
    do_move(2'b01, 1'b0);
    vectors++; if ({w_alive, w_wall_hit, w_self_hit} !== 3'b010) begin miscompares++;
      $display("FAIL wall_flags got %b want 010", {w_alive, w_wall_hit, w_self_hit}); end
    vectors++; if ({w_head_x, w_head_y} !== 6'o47) begin miscompares++;
      $display("FAIL wall_head got %o want 47", {w_head_x, w_head_y}); end
    vectors++; if ({r_head_x, r_head_y, r_alive} !== 7'b100_000_1) begin miscompares++;
      $display("FAIL wrap_head got %b want 1000001", {r_head_x, r_head_y, r_alive}); end
    vectors++; if (r_seg_y !== 24'o00000670) begin miscompares++;
      $display("FAIL wrap_seg_y got %o want 00000670", r_seg_y); end
    do_move(2'b11, 1'b1);
    do_move(2'b10, 1'b0);
    vectors++; if ({w_seg_x, w_seg_y} !== {24'o00000444, 24'o00000567}) begin miscompares++;
      $display("FAIL dead_segs got %o/%o want 444/567", w_seg_x, w_seg_y); end
    vectors++; if ({w_length, w_heading, w_alive, w_wall_hit, w_self_hit} !== 9'b0011_01_010)
    begin miscompares++;
      $display("FAIL dead_state got %b want 001101010",
               {w_length, w_heading, w_alive, w_wall_hit, w_self_hit}); end
  endtask

  task automatic test_reversal;
    do_reset(1'b0);
    do_move(2'b00, 1'b0);
    vectors++; if ({w_head_x, w_head_y, w_heading} !== 8'b100_101_01) begin miscompares++;
      $display("FAIL reversal got %b want 10010101", {w_head_x, w_head_y, w_heading}); end
  endtask

  task automatic test_grow_self_hit;
    do_reset(1'b0);
    do_move(2'b01, 1'b1);
    do_move(2'b01, 1'b1);
    vectors++; if (w_length !== 4'd5) begin miscompares++;
      $display("FAIL grow_length got %0d want 5", w_length); end
    vectors++; if ({w_seg_x, w_seg_y} !== {24'o00044444, 24'o00023456}) begin miscompares++;
      $display("FAIL grow_segs got %o/%o want 44444/23456", w_seg_x, w_seg_y); end
    grow = 1'b1; @(posedge clk); #1; grow = 1'b0;
    vectors++; if ({w_length, w_head_x, w_head_y} !== 10'b0101_100_110) begin miscompares++;
      $display("FAIL grow_idle got %b want 0101100110", {w_length, w_head_x, w_head_y}); end
    do_move(2'b11, 1'b0);
    vectors++; if ({w_head_x, w_head_y} !== 6'o56) begin miscompares++;
      $display("FAIL turn_right got %o want 56", {w_head_x, w_head_y}); end
    do_move(2'b00, 1'b0);
    vectors++; if ({w_head_x, w_head_y, w_heading} !== 8'b101_101_00) begin miscompares++;
      $display("FAIL turn_up got %b want 10110100", {w_head_x, w_head_y, w_heading}); end
    do_move(2'b10, 1'b0);
    vectors++; if ({w_alive, w_wall_hit, w_self_hit} !== 3'b001) begin miscompares++;
      $display("FAIL self_flags got %b want 001", {w_alive, w_wall_hit, w_self_hit}); end
    vectors++; if ({w_seg_x, w_seg_y} !== {24'o00044455, 24'o00045665}) begin miscompares++;
      $display("FAIL self_segs got %o/%o want 44455/45665", w_seg_x, w_seg_y); end
    vectors++; if ({w_length, w_heading} !== 6'b0101_00) begin miscompares++;
      $display("FAIL self_len_head got %b want 010100", {w_length, w_heading}); end
    // Reset wins over a simultaneous move and clears the sticky flags.
    do_reset(1'b1);
    vectors++; if ({w_head_x, w_head_y, w_alive, w_self_hit, w_length} !== 12'b100_100_1_0_0011)
    begin miscompares++;
      $display("FAIL mid_reset got %b want 100100100011",
               {w_head_x, w_head_y, w_alive, w_self_hit, w_length}); end
  endtask

  task automatic test_tail_chase;
    do_reset(1'b0);
    do_move(2'b01, 1'b1);
    do_move(2'b01, 1'b0);
    do_move(2'b11, 1'b0);
    do_move(2'b00, 1'b0);
    do_move(2'b10, 1'b0);
    vectors++; if ({w_head_x, w_head_y, w_alive, w_self_hit} !== 8'b100_101_1_0) begin
      miscompares++;
      $display("FAIL chase_head got %b want 10010110",
               {w_head_x, w_head_y, w_alive, w_self_hit}); end
    vectors++; if ({w_seg_x, w_seg_y, w_length} !== {24'o00004554, 24'o00006655, 4'd4}) begin
      miscompares++;
      $display("FAIL chase_segs got %o/%o/%0d want 4554/6655/4", w_seg_x, w_seg_y, w_length);
    end
  endtask

  task automatic test_saturate;
    logic [1:0] path [7];
    path = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00};
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) do_move(path[i], 1'b1);
    vectors++; if ({w_length, w_alive, w_head_x, w_head_y} !== 11'b1000_1_110_101) begin
      miscompares++;
      $display("FAIL sat_state got %b want 10001110101",
               {w_length, w_alive, w_head_x, w_head_y}); end
    vectors++; if ({w_seg_x, w_seg_y} !== {24'o44445666, 24'o45677765}) begin miscompares++;
      $display("FAIL sat_segs got %o/%o want 44445666/45677765", w_seg_x, w_seg_y); end
  endtask

  initial begin
    test_reset();
    test_wall_wrap();
    test_reversal();
    test_grow_self_hit();
    test_tail_chase();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
